seq_memory: RTL and testbench

Parametrised synchronous sequence memory for the game datapath. Holds the current challenge sequence and supports appending entries, random-access reads with a one-cycle registered response, and an autonomous playback engine that presents the stored sequence entry by entry under a valid/ready handshake. It sits between the game controller and the LED/button display logic, replacing fixed 16x4 lookup memories.

---
 rtl/seq_memory.sv | 148 ++++++++++++++
 tb/tb_seq_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_memory.sv
// Sequence memory: append, one-cycle registered random reads and a valid/ready playback engine.
// Optional macro SEQ_MEMORY_PRELOAD_EN: reset loads the built-in challenge table (len=11).
module seq_memory #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  append,
  input  logic [DATA_WIDTH-1:0] append_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_oob,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] play_data,
  output logic                  play_valid,
  input  logic                  play_ready,
  output logic                  play_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   len,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   len_q, len_d, idx_q, idx_d, eff_len, idx_inc;
  logic                  ovf_q, ovf_d, wr_en, rd_hit;
  logic                  rd_valid_q, rd_oob_q;
  logic [DATA_WIDTH-1:0] rd_data_q, play_data_q, play_data_d;
  logic                  play_valid_q, play_valid_d;
  state_t                state_q, state_d;

  assign busy     = (state_q != IDLE);
  assign full     = (len_q == DEPTH_L);
  assign empty    = (len_q == '0);
  assign len      = len_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_oob   = rd_oob_q;
  assign play_data  = play_data_q;
  assign play_valid = play_valid_q;
  assign play_done  = (state_q == DONE);

  assign wr_en   = reset_n && !clear && append && !busy && !full;
  // A read on the clear edge is judged against the emptied sequence.
  assign eff_len = clear ? '0 : len_q;
  assign rd_hit  = ({1'b0, rd_addr} < eff_len);
  assign idx_inc = idx_q + ONE;

  always_comb begin
    len_d = len_q;
    ovf_d = ovf_q;
    if (clear) begin
      len_d = '0;
      ovf_d = 1'b0;
    end else if (append && !busy) begin
      if (full) ovf_d = 1'b1;
      else      len_d = len_q + ONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    play_data_d  = play_data_q;
    play_valid_d = play_valid_q;
    if (clear) begin
      state_d      = IDLE;
      play_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          idx_d   = '0;
          state_d = (len_q != '0) ? FETCH : DONE;
        end
        FETCH: begin
          play_data_d  = mem_q[idx_q[ADDR_WIDTH-1:0]];
          play_valid_d = 1'b1;
          state_d      = PRESENT;
        end
        PRESENT: if (play_ready) begin
          play_valid_d = 1'b0;
          idx_d        = idx_inc;
          state_d      = (idx_inc == len_q) ? DONE : FETCH;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
`ifdef SEQ_MEMORY_PRELOAD_EN
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      mem_q[1]  <= DATA_WIDTH'(9);
      mem_q[2]  <= DATA_WIDTH'(6);
      mem_q[4]  <= DATA_WIDTH'(5);
      mem_q[5]  <= DATA_WIDTH'(3);
      mem_q[8]  <= DATA_WIDTH'(12);
      mem_q[10] <= DATA_WIDTH'(10);
    end else
`endif
    if (wr_en) mem_q[len_q[ADDR_WIDTH-1:0]] <= append_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
`ifdef SEQ_MEMORY_PRELOAD_EN
      len_q <= (ADDR_WIDTH+1)'(11);
`else
      len_q <= '0;
`endif
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= '0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_oob_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      play_data_q  <= play_data_d;
      play_valid_q <= play_valid_d;
      rd_valid_q   <= rd_en;
      if (rd_en) begin
        rd_oob_q  <= !rd_hit;
        rd_data_q <= rd_hit ? mem_q[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_memory.sv
// Self-checking bench for seq_memory: directed and randomized steps against a queue/array model.
module tb_seq_memory;

  logic       clock = 1'b0;
  logic       reset_n, clear, append, rd_en, start, play_ready;
  logic [3:0] append_data, rd_addr;
  logic [3:0] rd_data, play_data;
  logic       rd_valid, rd_oob, play_valid, play_done, busy, full, empty, overflow;
  logic [4:0] len;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] mmem [16];
  int         mlen;
  logic       movf;

  seq_memory #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .append(append),
    .append_data(append_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob), .start(start),
    .play_data(play_data), .play_valid(play_valid), .play_ready(play_ready),
    .play_done(play_done), .busy(busy), .len(len), .full(full),
    .empty(empty), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("len", 32'(len), 32'(mlen));
    chk("full", 32'(full), 32'(mlen == 16));
    chk("empty", 32'(empty), 32'(mlen == 0));
    chk("overflow", 32'(overflow), 32'(movf));
  endtask

  task automatic do_append(input logic [3:0] d);
    append = 1'b1; append_data = d;
    tick();
    append = 1'b0;
    if (mlen == 16) movf = 1'b1;
    else begin mmem[mlen] = d; mlen++; end
    chk_status();
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = 4'(a);
    tick();
    rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_oob", 32'(rd_oob), 32'(a >= mlen));
    chk("rd_data", 32'(rd_data), (a < mlen) ? 32'(mmem[a]) : 32'd0);
    tick();
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mlen = 0; movf = 1'b0;
    chk_status();
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  // Playback of the whole model sequence; stall_at selects an entry held back for stall_n cycles,
  // during which an append is attempted and must be ignored.
  task automatic play(input int stall_at, input int stall_n);
    int len0;
    len0 = mlen;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mlen == 0) begin
      chk("empty_done", 32'(play_done), 32'd1);
      chk("empty_valid", 32'(play_valid), 32'd0);
      tick();
      chk("empty_done_pulse", 32'(play_done), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_valid2", 32'(play_valid), 32'd0);
      return;
    end
    chk("busy_fetch", 32'(busy), 32'd1);
    chk("valid_fetch", 32'(play_valid), 32'd0);
    for (int i = 0; i < len0; i++) begin
      play_ready = (i == stall_at) ? 1'b0 : 1'b1;
      append = (i == 0); append_data = 4'hF;
      tick();
      append = 1'b0;
      chk("play_valid", 32'(play_valid), 32'd1);
      chk("play_data", 32'(play_data), 32'(mmem[i]));
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          append = 1'b1;
          tick();
          append = 1'b0;
          chk("stall_valid", 32'(play_valid), 32'd1);
          chk("stall_data", 32'(play_data), 32'(mmem[i]));
        end
        play_ready = 1'b1;
      end
      tick();
      chk("bubble_valid", 32'(play_valid), 32'd0);
      if (i == len0 - 1) begin
        chk("play_done", 32'(play_done), 32'd1);
        tick();
        chk("done_pulse", 32'(play_done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
      end else begin
        chk("no_done", 32'(play_done), 32'd0);
        chk("busy_mid", 32'(busy), 32'd1);
      end
    end
    play_ready = 1'b0;
    chk_status();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; append = 1'b0; rd_en = 1'b0; start = 1'b0;
    play_ready = 1'b0; append_data = '0; rd_addr = '0;
    mlen = 0; movf = 1'b0;
`ifdef SEQ_MEMORY_PRELOAD_EN
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    mmem[1] = 4'd9; mmem[2] = 4'd6; mmem[4] = 4'd5; mmem[5] = 4'd3;
    mmem[8] = 4'd12; mmem[10] = 4'd10;
    mlen = 11;
`endif
    tick(); tick();
    reset_n = 1'b1;
    // reset state
    chk_status();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_oob", 32'(rd_oob), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_play_valid", 32'(play_valid), 32'd0);
    chk("rst_play_data", 32'(play_data), 32'd0);
    chk("rst_play_done", 32'(play_done), 32'd0);
    for (int a = 0; a < 16; a++) do_read(a);
    play(-1, 0);

    // directed sequence 3,7,1
    do_clear();
    do_append(4'd3); do_append(4'd7); do_append(4'd1);
    do_read(1); do_read(3);
    play(-1, 0);
    play(1, 5);

    // back-to-back reads, one per cycle
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    chk("b2b_data0", 32'(rd_data), 32'd3);
    chk("b2b_valid0", 32'(rd_valid), 32'd1);
    rd_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    chk("b2b_data1", 32'(rd_data), 32'd1);
    chk("b2b_valid1", 32'(rd_valid), 32'd1);
    tick();
    chk("b2b_end", 32'(rd_valid), 32'd0);

    // read of the index being appended on the same edge sees the old length
    rd_en = 1'b1; rd_addr = 4'(mlen); append = 1'b1; append_data = 4'd5;
    tick();
    rd_en = 1'b0; append = 1'b0;
    chk("same_edge_oob", 32'(rd_oob), 32'd1);
    chk("same_edge_data", 32'(rd_data), 32'd0);
    mmem[mlen] = 4'd5; mlen++;
    chk_status();

    // clear with concurrent read: evaluated against emptied sequence
    rd_en = 1'b1; rd_addr = 4'd0; clear = 1'b1; append = 1'b1; start = 1'b1;
    tick();
    rd_en = 1'b0; clear = 1'b0; append = 1'b0; start = 1'b0;
    mlen = 0; movf = 1'b0;
    chk("clr_rd_valid", 32'(rd_valid), 32'd1);
    chk("clr_rd_oob", 32'(rd_oob), 32'd1);
    chk("clr_rd_data", 32'(rd_data), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk_status();

    // empty playback
    play(-1, 0);

    // fill to full, overflow, then clear
    for (int i = 0; i < 16; i++) do_append(4'($urandom_range(0, 15)));
    do_append(4'($urandom_range(0, 15)));
    for (int k = 0; k < 4; k++) do_read($urandom_range(0, 15));
    play($urandom_range(0, 15), 2);
    do_clear();

    // clear mid-playback
    do_append(4'd2); do_append(4'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_valid", 32'(play_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mlen = 0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid_off", 32'(play_valid), 32'd0);
    chk("mid_no_done", 32'(play_done), 32'd0);
    tick();
    chk("mid_no_done2", 32'(play_done), 32'd0);
    chk_status();

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      int n;
      do_clear();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) do_append(4'($urandom_range(0, 15)));
      play($urandom_range(0, n - 1), $urandom_range(1, 4));
      for (int k = 0; k < 3; k++) do_read($urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
